avmm_req_release_queue: RTL and testbench

- Sits directly upstream of the AVMM memory model; consumes `avmm_req` beats (688 bits, from `avmm_memory_pkg`) from the traffic source.
- Buffers requests in order and releases each one only when the free-running cycle time reaches its `timestamp + LATENCY`.
- The memory model therefore sees requests at their modelled issue time.
- Strictly in-order: a blocked head blocks all later entries.

---
 rtl/avmm_req_release_queue.sv | 74 +++++++
 tb/tb_avmm_req_release_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_req_release_queue.sv
// avmm_req_release_queue: in-order avmm_req buffer releasing each beat once cur_time >= timestamp + LATENCY.
// Define AVMM_REQ_STATS_EN to add the stat_reads/stat_writes/stat_max_occ outputs.
module avmm_req_release_queue #(
   parameter int          DEPTH   = 16,
   parameter logic [63:0] LATENCY = 64'd0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [687:0]           in_req,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [687:0]           out_req,
   output logic [63:0]            cur_time,
   output logic [$clog2(DEPTH):0] occupancy
`ifdef AVMM_REQ_STATS_EN
   ,
   output logic [31:0]            stat_reads,
   output logic [31:0]            stat_writes,
   output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);
   localparam int AW = $clog2(DEPTH);
   // Beat layout: read[687] write[686] address[685:640] byteenable[639:576] writedata[575:64] timestamp[63:0]
   logic [687:0] mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [687:0] head_req;
   logic [64:0] due_time;
   logic [AW:0] occ_next;
   logic push, store, due, pop;
   assign head_req = mem[head];
   // 65-bit sum: an overflowing deadline can never be reached by the 64-bit clock
   assign due_time = {1'b0, head_req[63:0]} + {1'b0, LATENCY};
   assign due = {1'b0, cur_time} >= due_time;
   assign push = in_valid && in_ready;
   assign store = push && (in_req[687] || in_req[686]);
   assign pop = (occupancy != '0) && due && (!out_valid || out_ready);
   assign occ_next = occupancy + {{AW{1'b0}}, store} - {{AW{1'b0}}, pop};
   always_ff @(posedge clk)
      if (store) mem[tail] <= in_req;
   always_ff @(posedge clk)
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_req   <= '0;
         cur_time  <= '0;
      end else begin
         cur_time  <= cur_time + 64'd1;
         occupancy <= occ_next;
         in_ready  <= occ_next != (AW+1)'(DEPTH);
         if (store) tail <= tail + AW'(1);
         if (pop) begin
            head      <= head + AW'(1);
            out_req   <= head_req;
            out_valid <= 1'b1;
         end else if (out_ready) out_valid <= 1'b0;
      end
`ifdef AVMM_REQ_STATS_EN
   always_ff @(posedge clk)
      if (rst) begin
         stat_reads   <= '0;
         stat_writes  <= '0;
         stat_max_occ <= '0;
      end else begin
         if (pop && head_req[687] && stat_reads != '1) stat_reads <= stat_reads + 32'd1;
         if (pop && head_req[686] && stat_writes != '1) stat_writes <= stat_writes + 32'd1;
         if (occ_next > stat_max_occ) stat_max_occ <= occ_next;
      end
`endif
endmodule

// File: tb/tb_avmm_req_release_queue.sv
// tb_avmm_req_release_queue: directed and random checks against a queue-based reference model.
module tb_avmm_req_release_queue;
   localparam int DEPTH = 16;
   localparam int AW = $clog2(DEPTH);
   localparam logic [63:0] LAT = 64'd3;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [687:0] in_req = '0;
   logic in_ready, out_valid;
   logic [687:0] out_req;
   logic [63:0] cur_time;
   logic [AW:0] occupancy;
   int tests = 0, fails = 0;
   logic [687:0] q[$];
   logic m_ov = 1'b0, m_ir = 1'b0;
   logic [687:0] m_out = '0;
   logic [63:0] m_time = '0;
`ifdef AVMM_REQ_STATS_EN
   logic [31:0] stat_reads, stat_writes;
   logic [AW:0] stat_max_occ;
   int m_reads = 0, m_writes = 0, m_max = 0;
`endif

   always #5 clk = ~clk;

   avmm_req_release_queue #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
      .out_valid(out_valid), .out_ready(out_ready), .out_req(out_req),
      .cur_time(cur_time), .occupancy(occupancy)
`ifdef AVMM_REQ_STATS_EN
      , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_max_occ(stat_max_occ)
`endif
   );

   function automatic logic [687:0] mk(input logic r, input logic w, input logic [63:0] ts);
      logic [687:0] v;
      for (int i = 0; i < 21; i++) v[i*32 +: 32] = $urandom;
      v[687:672] = 16'($urandom);
      v[687] = r;
      v[686] = w;
      v[63:0] = ts;
      return v;
   endfunction

   // Advance one clock edge, updating the reference model from the inputs seen at that edge
   task automatic tick();
      logic [687:0] h;
      logic pop;
      h = (q.size() != 0) ? q[0] : '0;
      pop = (q.size() != 0) && ({1'b0, m_time} >= {1'b0, h[63:0]} + {1'b0, LAT}) && (!m_ov || out_ready);
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_ov = 1'b0; m_out = '0; m_time = '0; m_ir = 1'b0;
`ifdef AVMM_REQ_STATS_EN
         m_reads = 0; m_writes = 0; m_max = 0;
`endif
      end else begin
         if (pop) begin
            m_out = q.pop_front();
            m_ov = 1'b1;
`ifdef AVMM_REQ_STATS_EN
            m_reads += int'(m_out[687]);
            m_writes += int'(m_out[686]);
`endif
         end else if (out_ready) m_ov = 1'b0;
         if (in_valid && m_ir && (in_req[687] || in_req[686])) q.push_back(in_req);
         m_time = m_time + 64'd1;
         m_ir = q.size() != DEPTH;
`ifdef AVMM_REQ_STATS_EN
         if (q.size() > m_max) m_max = q.size();
`endif
      end
      #1;
   endtask

   task automatic send(input logic [687:0] r);
      in_valid = 1'b1;
      in_req = r;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests++; if (out_req !== '0) begin fails++; $display("FAIL reset_out_req got=%h exp=0", out_req); end
      tests++; if (cur_time !== 64'd0) begin fails++; $display("FAIL reset_cur_time got=%0d exp=0", cur_time); end
      tests++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
      rst = 1'b0;
      tick();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
      tests++; if (cur_time !== 64'd1) begin fails++; $display("FAIL post_reset_cur_time got=%0d exp=1", cur_time); end
   endtask

   task automatic test_min_latency();
      logic [687:0] r;
      out_ready = 1'b1;
      while (cur_time < 64'd5) tick();
      r = mk(1'b1, 1'b0, 64'd0);
      send(r);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL minlat_early got=%b exp=0", out_valid); end
      tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL minlat_valid got=%b exp=1", out_valid); end
      tests++; if (out_req !== r) begin fails++; $display("FAIL minlat_data got=%h exp=%h", out_req, r); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL minlat_drop got=%b exp=0", out_valid); end
   endtask

   task automatic test_future_release();
      logic [63:0] ts, seen;
      logic [687:0] r;
      ts = cur_time + 64'd20;
      r = mk(1'b0, 1'b1, ts);
      send(r);
      seen = '1;
      for (int i = 0; i < 100 && seen == '1; i++) begin
         if (out_valid) seen = cur_time;
         else tick();
      end
      tests++; if (seen !== ts + LAT + 64'd1) begin fails++; $display("FAIL future_release_time got=%0d exp=%0d", seen, ts + LAT + 64'd1); end
      tests++; if (out_req !== r) begin fails++; $display("FAIL future_release_data got=%h exp=%h", out_req, r); end
      tick();
   endtask

   task automatic test_full();
      logic [687:0] exp[$];
      out_ready = 1'b0;
      for (int i = 0; i < 60 && exp.size() < DEPTH + 1; i++) begin
         in_valid = 1'b1;
         in_req = mk(1'b1, 1'b0, 64'd0);
         if (in_ready) exp.push_back(in_req);
         tick();
      end
      in_valid = 1'b0;
      tests++; if (exp.size() != DEPTH + 1) begin fails++; $display("FAIL full_accepted got=%0d exp=%0d", exp.size(), DEPTH + 1); end
      tests++; if (occupancy !== (AW+1)'(DEPTH)) begin fails++; $display("FAIL full_occupancy got=%0d exp=%0d", occupancy, DEPTH); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_out_valid got=%b exp=1", out_valid); end
      out_ready = 1'b1;
      foreach (exp[k]) begin
         tests++;
         if (out_valid !== 1'b1 || out_req !== exp[k]) begin
            fails++; $display("FAIL drain_beat%0d valid=%b got=%h exp=%h", k, out_valid, out_req, exp[k]);
         end
         tick();
      end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_end got=%b exp=0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL drain_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_nonmonotonic();
      logic [63:0] ts_a, seen;
      logic [687:0] a, b;
      ts_a = cur_time + 64'd40;
      a = mk(1'b1, 1'b0, ts_a);
      b = mk(1'b0, 1'b1, 64'd10);
      send(a);
      send(b);
      seen = '1;
      for (int i = 0; i < 100 && seen == '1; i++) begin
         if (out_valid) seen = cur_time;
         else tick();
      end
      tests++; if (seen !== ts_a + LAT + 64'd1) begin fails++; $display("FAIL nonmono_head_time got=%0d exp=%0d", seen, ts_a + LAT + 64'd1); end
      tests++; if (out_req !== a) begin fails++; $display("FAIL nonmono_head_data got=%h exp=%h", out_req, a); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_req !== b) begin fails++; $display("FAIL nonmono_second valid=%b got=%h exp=%h", out_valid, out_req, b); end
      tick();
   endtask

   task automatic test_null_and_overflow();
      logic any_valid;
      send(mk(1'b0, 1'b0, 64'd0));
      tests++; if (occupancy !== '0) begin fails++; $display("FAIL null_occupancy got=%0d exp=0", occupancy); end
      send(mk(1'b1, 1'b0, '1));
      any_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         any_valid |= out_valid;
         tick();
      end
      tests++; if (any_valid !== 1'b0) begin fails++; $display("FAIL overflow_released got=%b exp=0", any_valid); end
      tests++; if (occupancy !== (AW+1)'(1)) begin fails++; $display("FAIL overflow_occupancy got=%0d exp=1", occupancy); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL overflow_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset_midop();
      rst = 1'b1; tick(); rst = 1'b0; tick();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(mk(1'(i), 1'(~i), 64'd0));
      tests++; if (out_valid !== 1'b1 || occupancy !== (AW+1)'(3)) begin fails++; $display("FAIL midop_setup valid=%b occ=%0d exp=1/3", out_valid, occupancy); end
      rst = 1'b1;
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midop_out_valid got=%b exp=0", out_valid); end
      tests++; if (occupancy !== '0) begin fails++; $display("FAIL midop_occupancy got=%0d exp=0", occupancy); end
      tests++; if (cur_time !== 64'd0) begin fails++; $display("FAIL midop_cur_time got=%0d exp=0", cur_time); end
`ifdef AVMM_REQ_STATS_EN
      tests++; if (stat_reads !== '0 || stat_writes !== '0 || stat_max_occ !== '0) begin fails++; $display("FAIL midop_stats got=%0d/%0d/%0d exp=0", stat_reads, stat_writes, stat_max_occ); end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         in_valid = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 6;
         in_req = mk(1'($urandom), 1'($urandom), m_time + 64'($urandom_range(0, 12)) - 64'd5);
         tick();
         tests++; if (in_ready !== m_ir) begin fails++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, m_ir); end
         tests++; if (out_valid !== m_ov) begin fails++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, out_valid, m_ov); end
         tests++; if (out_req !== m_out) begin fails++; $display("FAIL rand_out_req cyc=%0d got=%h exp=%h", c, out_req, m_out); end
         tests++; if (occupancy !== (AW+1)'(q.size())) begin fails++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", c, occupancy, q.size()); end
         tests++; if (cur_time !== m_time) begin fails++; $display("FAIL rand_cur_time cyc=%0d got=%0d exp=%0d", c, cur_time, m_time); end
      end
      in_valid = 1'b0;
`ifdef AVMM_REQ_STATS_EN
      tests++; if (stat_reads !== 32'(m_reads)) begin fails++; $display("FAIL stat_reads got=%0d exp=%0d", stat_reads, m_reads); end
      tests++; if (stat_writes !== 32'(m_writes)) begin fails++; $display("FAIL stat_writes got=%0d exp=%0d", stat_writes, m_writes); end
      tests++; if (stat_max_occ !== (AW+1)'(m_max)) begin fails++; $display("FAIL stat_max_occ got=%0d exp=%0d", stat_max_occ, m_max); end
`endif
   endtask

   initial begin
      test_reset();
      test_min_latency();
      test_future_release();
      test_full();
      test_nonmonotonic();
      test_null_and_overflow();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
